// File: rtl/hazard_ctrl_param.sv
// Hazard/forwarding controller for the 5-stage MIPS core: Tuse/Tnew stall
// detection, newest-first forwarding selects, HI/LO busy tracking and stall stats.

module hazard_fwd_sel #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mDst,
    input  logic              mWe,
    input  logic [1:0]        mTnew,
    input  logic [REG_AW-1:0] wDst,
    input  logic              wWe,
    output logic [1:0]        fwd
);
    logic mHit, wHit;

    // M only forwards once its result exists; otherwise the stall logic holds D.
    assign mHit = (src != '0) && mWe && (mDst == src) && (mTnew == 2'd0);
    assign wHit = (src != '0) && wWe && (wDst == src);
    assign fwd  = mHit ? 2'd1 : (wHit ? 2'd2 : 2'd0);
endmodule

module hazard_ctrl_param #(
    parameter int REG_AW   = 5,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [1:0]        d_tuse_rs,
    input  logic [1:0]        d_tuse_rt,
    input  logic              d_md_use,
    input  logic [REG_AW-1:0] e_rs,
    input  logic [REG_AW-1:0] e_rt,
    input  logic [REG_AW-1:0] e_dst,
    input  logic              e_we,
    input  logic [1:0]        e_tnew,
    input  logic [REG_AW-1:0] m_rt,
    input  logic [REG_AW-1:0] m_dst,
    input  logic              m_we,
    input  logic [1:0]        m_tnew,
    input  logic [REG_AW-1:0] w_dst,
    input  logic              w_we,
    input  logic              e_md_start,
    input  logic              e_md_is_div,
    input  logic              clr_stats,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m,
    output logic              stall,
    output logic              md_busy,
    output logic              md_err,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [CNT_W-1:0] MULT_C = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic {IDLE, BUSY} mdStateT;

    mdStateT            mdState, mdStateNxt;
    logic [CNT_W-1:0]   mdCnt, mdCntNxt;
    logic [3:0][REG_AW-1:0] fwdSrc;
    logic [3:0][1:0]    fwdOut;
    logic               rsHaz, rtHaz, mdHaz;

    function automatic logic regMatch(input logic [REG_AW-1:0] src, input logic we,
                                      input logic [REG_AW-1:0] dst);
        return (src != '0) && we && (dst == src);
    endfunction

    assign fwdSrc = {e_rt, e_rs, d_rt, d_rs};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : gSel
            hazard_fwd_sel #(.REG_AW(REG_AW)) uSel (
                .src  (fwdSrc[g]),
                .mDst (m_dst),
                .mWe  (m_we),
                .mTnew(m_tnew),
                .wDst (w_dst),
                .wWe  (w_we),
                .fwd  (fwdOut[g])
            );
        end
    endgenerate

    assign fwd_rs_d = fwdOut[0];
    assign fwd_rt_d = fwdOut[1];
    assign fwd_rs_e = fwdOut[2];
    assign fwd_rt_e = fwdOut[3];
    assign fwd_rt_m = regMatch(m_rt, w_we, w_dst);

    // Stall when the consumer needs the value before the producer has it; Tuse=3 can't lose.
    assign rsHaz = (regMatch(d_rs, e_we, e_dst) && (d_tuse_rs < e_tnew)) ||
                   (regMatch(d_rs, m_we, m_dst) && (d_tuse_rs < m_tnew));
    assign rtHaz = (regMatch(d_rt, e_we, e_dst) && (d_tuse_rt < e_tnew)) ||
                   (regMatch(d_rt, m_we, m_dst) && (d_tuse_rt < m_tnew));
    assign mdHaz = d_md_use && (md_busy || e_md_start);
    assign stall = rsHaz || rtHaz || mdHaz;

    assign md_busy = (mdState == BUSY);

    always_comb begin
        mdStateNxt = mdState;
        mdCntNxt   = mdCnt;
        case (mdState)
            IDLE: if (e_md_start) begin
                mdCntNxt   = e_md_is_div ? DIV_C : MULT_C;
                mdStateNxt = BUSY;
            end
            BUSY: begin
                // A start arriving here is dropped; only the error flag records it.
                mdCntNxt = mdCnt - ONE_C;
                if (mdCnt == ONE_C) mdStateNxt = IDLE;
            end
            default: mdStateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdState   <= IDLE;
            mdCnt     <= '0;
            md_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            mdState <= mdStateNxt;
            mdCnt   <= mdCntNxt;
            if (clr_stats) begin
                md_err    <= 1'b0;
                stall_cnt <= '0;
            end else begin
                if (e_md_start && md_busy) md_err <= 1'b1;
                if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + ONE_C;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Self-checking bench for hazard_ctrl_param: vector table, directed HI/LO and
// statistics sequences, then random traffic against a timestamp-based reference model.

module tb_hazard_ctrl_param;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;
    localparam int SAT      = 15;

    logic       clk, reset_n;
    logic [4:0] d_rs, d_rt, e_rs, e_rt, e_dst, m_rt, m_dst, w_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_md_use, e_we, m_we, w_we, e_md_start, e_md_is_div, clr_stats;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic       fwd_rt_m, stall, md_busy, md_err;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl_param #(.REG_AW(5), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs),
        .d_tuse_rt(d_tuse_rt), .d_md_use(d_md_use), .e_rs(e_rs), .e_rt(e_rt), .e_dst(e_dst),
        .e_we(e_we), .e_tnew(e_tnew), .m_rt(m_rt), .m_dst(m_dst), .m_we(m_we), .m_tnew(m_tnew),
        .w_dst(w_dst), .w_we(w_we), .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
        .clr_stats(clr_stats), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
        .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .stall(stall), .md_busy(md_busy),
        .md_err(md_err), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] dRs, dRt; logic [1:0] tRs, tRt;
        logic [4:0] eRs, eRt, eDst; logic eWe; logic [1:0] eTnew;
        logic [4:0] mRt, mDst; logic mWe; logic [1:0] mTnew;
        logic [4:0] wDst; logic wWe;
    } inT;
    typedef struct { int fRsD, fRtD, fRsE, fRtE, fRtM, stl; } expT;
    typedef struct { inT in; expT exp; } vecT;

    int checks = 0, failures = 0;
    // Reference state: absolute cycle numbers instead of a down-counter.
    int cyc = 0, busyEnd = 0, scnt = 0;
    bit err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] s, input logic we, input logic [4:0] d);
        return (s != 0) && we && (d == s);
    endfunction

    function automatic int fsel(input logic [4:0] s);
        if (hit(s, m_we, m_dst) && m_tnew == 0) return 1;
        if (hit(s, w_we, w_dst)) return 2;
        return 0;
    endfunction

    function automatic bit needStall(input bit busy);
        bit r;
        r = (hit(d_rs, e_we, e_dst) && int'(d_tuse_rs) < int'(e_tnew)) ||
            (hit(d_rs, m_we, m_dst) && int'(d_tuse_rs) < int'(m_tnew)) ||
            (hit(d_rt, e_we, e_dst) && int'(d_tuse_rt) < int'(e_tnew)) ||
            (hit(d_rt, m_we, m_dst) && int'(d_tuse_rt) < int'(m_tnew));
        return r || (d_md_use && (busy || e_md_start));
    endfunction

    task automatic applyIn(input inT v);
        d_rs = v.dRs; d_rt = v.dRt; d_tuse_rs = v.tRs; d_tuse_rt = v.tRt;
        e_rs = v.eRs; e_rt = v.eRt; e_dst = v.eDst; e_we = v.eWe; e_tnew = v.eTnew;
        m_rt = v.mRt; m_dst = v.mDst; m_we = v.mWe; m_tnew = v.mTnew;
        w_dst = v.wDst; w_we = v.wWe;
        d_md_use = 0; e_md_start = 0; e_md_is_div = 0; clr_stats = 0;
    endtask

    // Check every output against the model, then advance one clock with the model.
    task automatic doCycle();
        bit busy, st;
        #1;
        busy = (cyc < busyEnd);
        st   = needStall(busy);
        chk("m_fwd_rs_d", fwd_rs_d, fsel(d_rs));
        chk("m_fwd_rt_d", fwd_rt_d, fsel(d_rt));
        chk("m_fwd_rs_e", fwd_rs_e, fsel(e_rs));
        chk("m_fwd_rt_e", fwd_rt_e, fsel(e_rt));
        chk("m_fwd_rt_m", fwd_rt_m, hit(m_rt, w_we, w_dst));
        chk("m_stall", stall, st);
        chk("m_md_busy", md_busy, busy);
        chk("m_md_err", md_err, err);
        chk("m_stall_cnt", stall_cnt, scnt);
        @(posedge clk);
        if (!reset_n) begin
            busyEnd = 0; err = 0; scnt = 0;
        end else begin
            if (e_md_start && !busy) busyEnd = cyc + 1 + (e_md_is_div ? DIV_LAT : MULT_LAT);
            if (clr_stats) begin
                err = 0; scnt = 0;
            end else begin
                if (e_md_start && busy) err = 1;
                if (st && scnt < SAT) scnt++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    vecT tbl[12];
    inT  zero;
    int  busyN, stN;

    initial begin
        zero = '{0,0,3,3,0,0,0,0,0,0,0,0,0,0,0};
        tbl[0]  = '{'{0,0,3,3,0,0,0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0}};
        tbl[1]  = '{'{8,0,0,3,0,0,8,1,2,0,0,0,0,0,0}, '{0,0,0,0,0,1}};
        tbl[2]  = '{'{8,0,0,3,0,0,0,0,0,0,8,1,1,0,0}, '{0,0,0,0,0,1}};
        tbl[3]  = '{'{8,0,0,3,0,0,0,0,0,0,0,0,0,8,1}, '{2,0,0,0,0,0}};
        tbl[4]  = '{'{0,0,3,3,5,0,0,0,0,0,5,1,0,5,1}, '{0,0,1,0,0,0}};
        tbl[5]  = '{'{0,0,3,3,0,0,0,0,0,0,0,1,0,0,1}, '{0,0,0,0,0,0}};
        tbl[6]  = '{'{7,0,3,3,0,0,7,1,2,0,0,0,0,0,0}, '{0,0,0,0,0,0}};
        tbl[7]  = '{'{0,9,3,1,0,0,9,1,1,0,0,0,0,0,0}, '{0,0,0,0,0,0}};
        tbl[8]  = '{'{0,9,3,1,0,0,0,0,0,0,9,1,2,0,0}, '{0,0,0,0,0,1}};
        tbl[9]  = '{'{4,0,0,3,0,0,4,0,2,0,0,0,0,0,0}, '{0,0,0,0,0,0}};
        tbl[10] = '{'{0,6,3,1,0,6,0,0,0,6,0,0,0,6,1}, '{0,2,0,2,1,0}};
        tbl[11] = '{'{3,0,1,3,3,0,0,0,0,0,3,1,0,3,1}, '{1,0,1,0,0,0}};

        reset_n = 0;
        applyIn(zero);
        #2;
        chk("rst_md_busy", md_busy, 0);
        chk("rst_md_err", md_err, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        reset_n = 1;
        doCycle();

        // Vector table: forwarding and register stalls with HI/LO idle.
        for (int i = 0; i < 12; i++) begin
            applyIn(tbl[i].in);
            #1;
            chk($sformatf("t%0d_fwd_rs_d", i), fwd_rs_d, tbl[i].exp.fRsD);
            chk($sformatf("t%0d_fwd_rt_d", i), fwd_rt_d, tbl[i].exp.fRtD);
            chk($sformatf("t%0d_fwd_rs_e", i), fwd_rs_e, tbl[i].exp.fRsE);
            chk($sformatf("t%0d_fwd_rt_e", i), fwd_rt_e, tbl[i].exp.fRtE);
            chk($sformatf("t%0d_fwd_rt_m", i), fwd_rt_m, tbl[i].exp.fRtM);
            chk($sformatf("t%0d_stall", i), stall, tbl[i].exp.stl);
            doCycle();
        end

        // Divide: busy for exactly DIV_LAT cycles, mfhi stalls through the last one.
        applyIn(zero);
        e_md_start = 1; e_md_is_div = 1; d_md_use = 1;
        #1; chk("div_start_stall", stall, 1);
        doCycle();
        e_md_start = 0; e_md_is_div = 0;
        busyN = 0; stN = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (md_busy) busyN++;
            if (stall) stN++;
            doCycle();
        end
        chk("div_busy_len", busyN, DIV_LAT);
        chk("mfhi_stall_len", stN, DIV_LAT);

        // Start while busy: error set, busy window unchanged, clr_stats clears it.
        applyIn(zero);
        e_md_start = 1;
        doCycle();
        e_md_is_div = 1;
        busyN = 0;
        for (int i = 0; i < 13; i++) begin
            #1;
            if (md_busy) busyN++;
            doCycle();
            e_md_start = 0; e_md_is_div = 0;
        end
        chk("mult_busy_len", busyN, MULT_LAT);
        #1; chk("md_err_set", md_err, 1);
        clr_stats = 1;
        doCycle();
        clr_stats = 0;
        #1; chk("md_err_clr", md_err, 0);
        doCycle();

        // Saturation of the stall counter, then clear beating an increment.
        applyIn(tbl[1].in);
        clr_stats = 1;
        doCycle();
        clr_stats = 0;
        for (int i = 0; i < 20; i++) doCycle();
        #1; chk("stall_cnt_sat", stall_cnt, SAT);
        clr_stats = 1;
        doCycle();
        clr_stats = 0;
        #1; chk("stall_cnt_clr", stall_cnt, 0);
        doCycle();

        // Async reset mid-multiply.
        applyIn(zero);
        e_md_start = 1;
        doCycle();
        e_md_start = 0;
        for (int i = 0; i < 3; i++) doCycle();
        #1; chk("mult_busy_pre_rst", md_busy, 1);
        reset_n = 0;
        busyEnd = 0; err = 0; scnt = 0;
        #1; chk("rst_async_busy", md_busy, 0);
        d_md_use = 1;
        #1; chk("rst_mflo_stall", stall, 0);
        doCycle();
        reset_n = 1;
        doCycle();

        // Random traffic with a small register pool to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
            d_tuse_rs = 2'($urandom); d_tuse_rt = 2'($urandom);
            e_rs = 5'($urandom_range(0, 3)); e_rt = 5'($urandom_range(0, 3));
            e_dst = 5'($urandom_range(0, 3)); e_we = 1'($urandom); e_tnew = 2'($urandom_range(0, 2));
            m_rt = 5'($urandom_range(0, 3)); m_dst = 5'($urandom_range(0, 3));
            m_we = 1'($urandom); m_tnew = 2'($urandom_range(0, 1));
            w_dst = 5'($urandom_range(0, 3)); w_we = 1'($urandom);
            d_md_use = ($urandom_range(0, 3) == 0);
            e_md_start = ($urandom_range(0, 5) == 0);
            e_md_is_div = 1'($urandom);
            clr_stats = ($urandom_range(0, 15) == 0);
            doCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
